stream_mux_nx1: RTL and testbench
=================================

Name: stream_mux_nx1

Overview:
- Parametrised N-input to 1-output registered stream multiplexer with a valid/ready handshake on every channel.
- Successor to the plain combinational 2:1 mux: selection comes from an internal arbiter (round-robin or fixed priority), not a SEL pin.
- The result is registered with backpressure support.
- Sits between multiple producer channels and a single shared consumer, e.g. a shared bus or FIFO write port.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (2..16).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- CLK  input  1  system clock, rising edge.
- RSTn  input  1  asynchronous active-low reset.
- IN_DATA  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  input  N  per-channel valid.
- IN_LAST  input  N  per-channel end-of-packet marker.
- IN_READY  output  N  per-channel ready; at most one bit set per cycle.
- OUT_DATA  output  WIDTH  registered selected data.
- OUT_VALID  output  1  registered output valid.
- OUT_LAST  output  1  registered LAST of the selected beat.
- OUT_SEL  output  SELW  registered index of the channel that supplied the current beat.
- OUT_READY  input  1  consumer ready.

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - Reset is asynchronous and active-low on RSTn.
  - Reset values: OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, OUT_SEL=0, round-robin pointer=0, lock flag=0.
- Widths and register load:
  - SELW = max(1, clog2(N)).
  - accept = !OUT_VALID || OUT_READY. The output register loads when accept is high and any IN_VALID bit is set.
- Grant and handshake:
  - Grant is combinational from IN_VALID, the pointer and the lock state.
  - IN_READY[i] = accept && grant[i]. A transfer on channel i occurs when IN_VALID[i] && IN_READY[i].
  - IN_READY depends combinationally on OUT_READY and IN_VALID. Producers must not make IN_VALID depend on IN_READY.
  - IN_READY is all-zero when no input is valid.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge k is visible on OUT_* after edge k.
  - Throughput is 1 beat per cycle with OUT_READY held high.
  - Back-to-back beats from different channels need no bubble.
- Backpressure:
  - While OUT_VALID && !OUT_READY, OUT_DATA, OUT_LAST and OUT_SEL hold stable and all IN_READY bits are 0.
- Dequeue without refill:
  - If OUT_VALID && OUT_READY and no input is valid, OUT_VALID goes to 0 on the next edge. OUT_DATA holds its last value.
- Round-robin (MODE=0):
  - Search starts at the pointer and wraps from N-1 to 0.
  - After each granted transfer, pointer = granted index + 1, with N-1 wrapping to 0.
  - The pointer is unchanged when nothing transfers.
- Fixed priority (MODE=1):
  - The lowest-index valid channel wins.
  - The pointer is unused and held at 0.
- Grant changes while stalled:
  - When accept=0, the arbiter may change its grant.
  - No state updates occur without a transfer.
- Reset mid-operation:
  - Asserting RSTn low drops OUT_VALID immediately (asynchronously).
  - Any held beat is discarded. Producers see IN_READY=0 throughout reset.
- Illegal parameters: N<2 or MODE>1 are fatal at elaboration (generate-time check).

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - After a transfer from channel i with IN_LAST[i]=0, the lock flag is set and grant is forced to channel i only. Other channels see IN_READY=0 even if valid.
  - If channel i deasserts IN_VALID mid-packet, no channel transfers.
  - The lock clears on transfer of a beat with IN_LAST[i]=1.
  - Round-robin pointer update is deferred to that last beat. A single-beat packet (LAST=1 on first beat) never locks.
- Not defined:
  - Arbitration is per beat.
  - IN_LAST is only passed through to OUT_LAST. The lock flag does not exist.

Decomposition:
- Package stream_mux_pkg:
  - Mode constants MUX_MODE_RR=0 and MUX_MODE_FIXED=1.
  - A clog2 function for SELW.
- Sub-module arb_nx1:
  - Parameters N and MODE.
  - Inputs: REQ[N], ADVANCE, HOLD and HOLD_IDX.
  - Outputs: one-hot GNT[N] and GNT_IDX.
  - Contains the pointer register (CLK, RSTn).
- stream_mux_nx1 contains the output register, handshake logic and lock flag.

Test Plan (WIDTH=8, N=4):
- Reset then idle: hold RSTn=0 for 3 cycles, then release with all IN_VALID=0 -> OUT_VALID=0, OUT_DATA=0x00, OUT_SEL=0, IN_READY=0000.
- Round-robin fairness: MODE=0, all four channels valid continuously with data 0xA0..0xA3, OUT_READY=1 -> OUT_SEL sequence 0,1,2,3,0,... and OUT_DATA 0xA0,0xA1,0xA2,0xA3,0xA0, one beat per cycle.
- Fixed priority: MODE=1, channels 1 and 3 valid (0x11, 0x33) -> only channel 1 is granted while valid. Channel 3 (0x33) transfers the cycle after channel 1 drops valid.
- Backpressure: OUT_VALID=1 holding 0x5A, OUT_READY=0 for 4 cycles -> OUT_DATA stays 0x5A, IN_READY=0000. OUT_READY=1 -> next beat loads the following cycle.
- Async reset mid-stream: drop RSTn between edges while OUT_VALID=1 -> OUT_VALID=0 before the next edge. After release, round-robin restarts at channel 0.
- Packet lock (with STREAM_MUX_PKT_LOCK_EN): channel 2 sends a 3-beat packet (LAST on beat 3) while channel 0 is valid -> OUT_SEL=2,2,2 then 0. Without the macro -> OUT_SEL alternates 2,0,...

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and elaboration helpers for the N:1 stream multiplexer
// and its arbiter.
package stream_mux_pkg;

   localparam int unsigned MUX_MODE_RR    = 0;
   localparam int unsigned MUX_MODE_FIXED = 1;

   localparam int unsigned MUX_N_MIN = 2;
   localparam int unsigned MUX_N_MAX = 16;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) result++;
      return result;
   endfunction

   // Select index width; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/arb_nx1.sv
// N-way arbiter: round-robin (pointer register) or fixed lowest-index priority,
// with an external hold that pins the grant to one channel.
module arb_nx1
   import stream_mux_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned MODE = MUX_MODE_RR,
   localparam int unsigned SELW = sel_width(N)
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic [N-1:0]    REQ,
   input  logic            ADVANCE,
   input  logic            HOLD,
   input  logic [SELW-1:0] HOLD_IDX,
   output logic [N-1:0]    GNT,
   output logic [SELW-1:0] GNT_IDX
);

   logic [SELW-1:0] ptr_q, ptr_d;
   logic [SELW-1:0] search_idx;
   logic [SELW-1:0] cand_idx;
   logic            search_hit;
   int unsigned     cand;

   // Search upward from the pointer with wrap; the pointer is pinned at 0 in
   // fixed-priority mode, which turns the same search into lowest-index-wins.
   always_comb begin
      search_idx = '0;
      search_hit = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = 32'(ptr_q) + k;
         if (cand >= N) cand = cand - N;
         cand_idx = SELW'(cand);
         if (!search_hit && REQ[cand_idx]) begin
            search_hit = 1'b1;
            search_idx = cand_idx;
         end
      end
   end

   always_comb begin
      GNT     = '0;
      GNT_IDX = search_idx;
      if (HOLD) begin
         GNT_IDX = HOLD_IDX;
         if (REQ[HOLD_IDX]) GNT[HOLD_IDX] = 1'b1;
      end else if (search_hit) begin
         GNT[search_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (ADVANCE) ptr_d = (32'(GNT_IDX) == N - 1) ? '0 : GNT_IDX + 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ptr_q <= '0;
      end else if (MODE == MUX_MODE_RR) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/stream_mux_nx1.sv
// Registered N:1 valid/ready stream multiplexer with internal arbitration.
// Optional packet lock (grant held until LAST) enabled by STREAM_MUX_PKT_LOCK_EN.
module stream_mux_nx1
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned MODE  = MUX_MODE_RR,
   localparam int unsigned SELW = sel_width(N)
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic [N*WIDTH-1:0] IN_DATA,
   input  logic [N-1:0]       IN_VALID,
   input  logic [N-1:0]       IN_LAST,
   output logic [N-1:0]       IN_READY,
   output logic [WIDTH-1:0]   OUT_DATA,
   output logic               OUT_VALID,
   output logic               OUT_LAST,
   output logic [SELW-1:0]    OUT_SEL,
   input  logic               OUT_READY
);

   if (N < MUX_N_MIN || N > MUX_N_MAX || MODE > MUX_MODE_FIXED) begin : g_bad_param
      $fatal(1, "stream_mux_nx1: unsupported N=%0d MODE=%0d", N, MODE);
   end

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic [SELW-1:0]  sel_q, sel_d;

   logic [N-1:0]     gnt;
   logic [SELW-1:0]  gnt_idx;
   logic             accept;
   logic             xfer;
   logic             advance;
   logic             hold;
   logic [SELW-1:0]  hold_idx;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;

   assign accept   = !valid_q || OUT_READY;
   // Gated by RSTn so producers never see a ready while the mux is in reset.
   assign IN_READY = (accept && RSTn) ? gnt : '0;
   assign xfer     = |(IN_VALID & IN_READY);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt[i]) begin
            sel_data = IN_DATA[i*WIDTH +: WIDTH];
            sel_last = IN_LAST[i];
         end
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic            lock_q, lock_d;
   logic [SELW-1:0] lock_idx_q, lock_idx_d;

   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (xfer) begin
         lock_d     = !sel_last;
         lock_idx_d = gnt_idx;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   assign hold     = lock_q;
   assign hold_idx = lock_idx_q;
   assign advance  = xfer && sel_last;
`else
   assign hold     = 1'b0;
   assign hold_idx = '0;
   assign advance  = xfer;
`endif

   arb_nx1 #(
      .N    (N),
      .MODE (MODE)
   ) u_arb (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .REQ      (IN_VALID),
      .ADVANCE  (advance),
      .HOLD     (hold),
      .HOLD_IDX (hold_idx),
      .GNT      (gnt),
      .GNT_IDX  (gnt_idx)
   );

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      sel_d   = sel_q;
      if (accept) valid_d = xfer;
      if (xfer) begin
         data_d = sel_data;
         last_d = sel_last;
         sel_d  = gnt_idx;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         sel_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
      end
   end

   assign OUT_DATA  = data_q;
   assign OUT_VALID = valid_q;
   assign OUT_LAST  = last_q;
   assign OUT_SEL   = sel_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed bench for stream_mux_nx1: one round-robin and one fixed-priority
// instance share stimulus; expectations follow STREAM_MUX_PKT_LOCK_EN.
module tb_stream_mux_nx1;

`ifdef STREAM_MUX_PKT_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic        out_ready;

   logic [3:0]  rr_ready, fp_ready;
   logic [7:0]  rr_data, fp_data;
   logic        rr_valid, fp_valid;
   logic        rr_last, fp_last;
   logic [1:0]  rr_sel, fp_sel;

   int checks = 0;
   int errors = 0;

   stream_mux_nx1 #(.WIDTH(8), .N(4), .MODE(0)) u_rr (
      .CLK       (clk),
      .RSTn      (rst_n),
      .IN_DATA   (in_data),
      .IN_VALID  (in_valid),
      .IN_LAST   (in_last),
      .IN_READY  (rr_ready),
      .OUT_DATA  (rr_data),
      .OUT_VALID (rr_valid),
      .OUT_LAST  (rr_last),
      .OUT_SEL   (rr_sel),
      .OUT_READY (out_ready)
   );

   stream_mux_nx1 #(.WIDTH(8), .N(4), .MODE(1)) u_fp (
      .CLK       (clk),
      .RSTn      (rst_n),
      .IN_DATA   (in_data),
      .IN_VALID  (in_valid),
      .IN_LAST   (in_last),
      .IN_READY  (fp_ready),
      .OUT_DATA  (fp_data),
      .OUT_VALID (fp_valid),
      .OUT_LAST  (fp_last),
      .OUT_SEL   (fp_sel),
      .OUT_READY (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic rr_beat(input string tag, input logic [1:0] sel, input logic [7:0] data);
      chk({tag, "_valid"}, 32'(rr_valid), 32'd1);
      chk({tag, "_sel"},   32'(rr_sel),   32'(sel));
      chk({tag, "_data"},  32'(rr_data),  32'(data));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 4'hF;
      in_last   = '0;
      out_ready = 1'b1;

      // Reset then idle; requests during reset must see no ready
      repeat (3) tick();
      #1;
      chk("rst_ready_rr", 32'(rr_ready), 32'h0);
      chk("rst_ready_fp", 32'(fp_ready), 32'h0);
      in_valid = '0;
      rst_n    = 1'b1;
      tick();
      chk("idle_valid", 32'(rr_valid), 32'd0);
      chk("idle_data",  32'(rr_data),  32'h00);
      chk("idle_sel",   32'(rr_sel),   32'd0);
      chk("idle_last",  32'(rr_last),  32'd0);
      chk("idle_ready", 32'(rr_ready), 32'h0);

      // Round-robin fairness
      in_data  = 32'hA3A2A1A0;
      in_valid = 4'hF;
      in_last  = 4'hF;
      #1;
      chk("rr_ready0", 32'(rr_ready), 32'b0001);
      for (int b = 0; b < 6; b++) begin
         tick();
         rr_beat($sformatf("rr_b%0d", b), 2'(b % 4), 8'hA0 + 8'(b % 4));
         chk($sformatf("rr_rdy%0d", b), 32'(rr_ready), 32'(4'b0001 << ((b + 1) % 4)));
      end

      // Dequeue without refill: valid drops, data holds
      in_valid = '0;
      tick();
      chk("drain_valid", 32'(rr_valid), 32'd0);
      chk("drain_data",  32'(rr_data),  32'hA1);
      chk("drain_ready", 32'(rr_ready), 32'h0);

      // Backpressure on 0x5A from channel 2
      in_data   = 32'h005A_0000;
      in_valid  = 4'b0100;
      in_last   = 4'b0100;
      out_ready = 1'b0;
      #1;
      chk("bp_ready_empty", 32'(rr_ready), 32'b0100);
      tick();
      rr_beat("bp_load", 2'd2, 8'h5A);
      in_data  = 32'h0000_0077;
      in_valid = 4'b0001;
      in_last  = 4'b0001;
      #1;
      chk("bp_ready_stall", 32'(rr_ready), 32'h0);
      for (int c = 0; c < 4; c++) begin
         tick();
         rr_beat($sformatf("bp_hold%0d", c), 2'd2, 8'h5A);
         chk($sformatf("bp_rdy%0d", c), 32'(rr_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(rr_ready), 32'b0001);
      tick();
      rr_beat("bp_next", 2'd0, 8'h77);

      // Async reset mid-stream; pointer was 1, must restart at channel 0
      in_data  = 32'hA3A2A1A0;
      in_valid = 4'hF;
      in_last  = 4'hF;
      #1;
      chk("pre_rst_ready", 32'(rr_ready), 32'b0010);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(rr_valid), 32'd0);
      chk("arst_data",  32'(rr_data),  32'h00);
      chk("arst_ready", 32'(rr_ready), 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(rr_ready), 32'b0001);
      tick();
      rr_beat("post_rst", 2'd0, 8'hA0);

      // Packet on channel 2 (3 beats) while channel 0 is valid; pointer is 1
      in_data  = 32'h00C0_000B;
      in_valid = 4'b0101;
      in_last  = 4'b0001;
      #1;
      chk("pkt_ready1", 32'(rr_ready), 32'b0100);
      tick();
      rr_beat("pkt_b1", 2'd2, 8'hC0);
      chk("pkt_b1_last", 32'(rr_last), 32'd0);
      in_data = 32'h00C1_000B;
      #1;
      chk("pkt_ready2", 32'(rr_ready), LOCK ? 32'b0100 : 32'b0001);
      tick();
      if (LOCK) rr_beat("pkt_b2", 2'd2, 8'hC1);
      else      rr_beat("pkt_b2", 2'd0, 8'h0B);
      chk("pkt_b2_last", 32'(rr_last), LOCK ? 32'd0 : 32'd1);
      in_data = 32'h00C2_000B;
      in_last = 4'b0101;
      #1;
      chk("pkt_ready3", 32'(rr_ready), 32'b0100);
      tick();
      rr_beat("pkt_b3", 2'd2, 8'hC2);
      chk("pkt_b3_last", 32'(rr_last), 32'd1);
      in_data = 32'h00C3_000B;
      #1;
      chk("pkt_ready4", 32'(rr_ready), 32'b0001);
      tick();
      rr_beat("pkt_b4", 2'd0, 8'h0B);

      // Fixed priority: channel 1 beats channel 3 until it drops
      in_data  = 32'h3300_1100;
      in_valid = 4'b1010;
      in_last  = 4'b1010;
      #1;
      chk("fp_ready_both", 32'(fp_ready), 32'b0010);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("fp_sel%0d", c),  32'(fp_sel),   32'd1);
         chk($sformatf("fp_data%0d", c), 32'(fp_data),  32'h11);
         chk($sformatf("fp_rdy%0d", c),  32'(fp_ready), 32'b0010);
      end
      in_valid = 4'b1000;
      #1;
      chk("fp_ready_ch3", 32'(fp_ready), 32'b1000);
      tick();
      chk("fp_ch3_valid", 32'(fp_valid), 32'd1);
      chk("fp_ch3_sel",   32'(fp_sel),   32'd3);
      chk("fp_ch3_data",  32'(fp_data),  32'h33);
      in_valid = '0;
      tick();
      chk("fp_drain_valid", 32'(fp_valid), 32'd0);
      chk("fp_drain_data",  32'(fp_data),  32'h33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
